// File: rtl/lz77_enc_sched.sv
// lz77_enc_sched: round-robin scheduler sharing one LZ77 encoder core between two requesters
module lz77_enc_sched #(
    parameter int IN_LEN     = 22,
    parameter int AW         = 5,
    parameter int FIFO_DEPTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    output logic [1:0]    grant,
    output logic [1:0]    done,
    output logic          rd_en,
    output logic          rd_sel,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          enc_reset,
    output logic [7:0]    enc_chardata,
    input  logic          enc_valid,
    input  logic          enc_finish,
    input  logic [3:0]    enc_offset,
    input  logic [2:0]    enc_match_len,
    input  logic [7:0]    enc_char_nxt,
    output logic          tok_valid,
    input  logic          tok_ready,
    output logic [14:0]   tok_data,
    output logic          tok_src,
    output logic          ovf
);
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RST, LOAD, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] k;
    logic          rr_ptr;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   count;
    logic          start, last_ld, pick, push, pop, full, wr_ok;

    // a job is admitted only when the FIFO can absorb a whole job's worth of tokens
    assign start   = |req && count <= (FW+1)'(FIFO_DEPTH - IN_LEN);
    assign pick    = &req ? rr_ptr : req[1];
    assign last_ld = k == AW'(IN_LEN - 1);
    assign push    = state == RUN && enc_valid;
    assign pop     = tok_valid && tok_ready;
    assign full    = count == (FW+1)'(FIFO_DEPTH);
    assign wr_ok   = push && !full;

    // state register
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    // job sequencing: admit, reset encoder, stream characters, wait for finish
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RST : IDLE;
            RST:     state_nxt = LOAD;
            LOAD:    state_nxt = last_ld ? RUN : LOAD;
            RUN:     state_nxt = enc_finish ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: buffer reads run one character ahead of the encoder feed
    always_comb begin
        done                = state == DONE ? grant : 2'b00;
        rd_en               = state == RST || (state == LOAD && !last_ld);
        rd_addr             = state == LOAD && !last_ld ? k + AW'(1) : '0;
        rd_sel              = grant[1];
        enc_reset           = reset || state == RST;
        enc_chardata        = state == LOAD ? rd_data : 8'h00;
        tok_valid           = count != '0;
        {tok_data, tok_src} = mem[rd_ptr];
    end

    // job ownership, load counter and round-robin pointer
    always_ff @(posedge clk)
        if (reset) begin
            grant  <= 2'b00;
            k      <= '0;
            rr_ptr <= 1'b0;
        end else begin
            if (state == IDLE && start) grant <= pick ? 2'b10 : 2'b01;
            if (state == DONE) begin
                grant  <= 2'b00;
                rr_ptr <= ~grant[1];
            end
            k <= state == LOAD ? k + AW'(1) : '0;
        end

    // token storage, tagged with the owner in the low bit
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= {enc_offset, enc_match_len, enc_char_nxt, grant[1]};

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            count <= count + (FW+1)'(wr_ok) - (FW+1)'(pop);
            if (push && full) ovf <= 1'b1;
        end
endmodule
